// File: rtl/step_clock_gen.sv
// Processor clock generator for the countdown board: debounced single-step
// from KEY or a selectable free-running divider, plus a step pulse and edge count.
module step_clock_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_HALF        = 390625
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_n,
  input  logic       run,
  input  logic [1:0] rate,
  output logic       step_clk,
  output logic       step_pulse,
  output logic       key_level,
  output logic [7:0] step_count
);

  localparam int DBW  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DIVW = 25;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      keySync_q, runSync_q;
  logic            keyLevel_q, keyLevel_d;
  logic [DBW-1:0]  dbCnt_q, dbCnt_d;
  logic [DIVW-1:0] div_q, div_d;
  logic            stepClk_q, stepClk_d;
  logic            stepPulse_q, stepPulse_d;
  logic [7:0]      stepCount_q, stepCount_d;
  logic            forceLow_q, forceLow_d;

  logic            keyPressed, runMode, risingEdge;
  logic [DIVW-1:0] halfPeriod;

  assign keyPressed = ~keySync_q[1];
  assign runMode    = runSync_q[1];
  assign halfPeriod = DIVW'(RUN_HALF) << {rate, 1'b0};

  always_comb begin
    keyLevel_d  = keyLevel_q;
    dbCnt_d     = '0;
    div_d       = '0;
    stepClk_d   = stepClk_q;
    forceLow_d  = forceLow_q;

    if (keyPressed != keyLevel_q) begin
      if (dbCnt_q == DB_LAST) begin
        keyLevel_d = ~keyLevel_q;
      end else begin
        dbCnt_d = dbCnt_q + 1'b1;
      end
    end

    // Run mode arms the force flag so a key still held when returning to
    // step mode cannot produce an edge until it has been seen released.
    if (runMode) begin
      forceLow_d = 1'b1;
      if (div_q >= halfPeriod - DIVW'(1)) begin
        stepClk_d = ~stepClk_q;
      end else begin
        div_d = div_q + DIVW'(1);
      end
    end else begin
      stepClk_d  = keyLevel_q & ~forceLow_q;
      forceLow_d = forceLow_q & keyLevel_q;
    end

    risingEdge  = stepClk_d & ~stepClk_q;
    stepPulse_d = risingEdge;
    stepCount_d = stepCount_q + {7'b0, risingEdge};
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      keySync_q   <= 2'b11;
      runSync_q   <= 2'b00;
      keyLevel_q  <= 1'b0;
      dbCnt_q     <= '0;
      div_q       <= '0;
      stepClk_q   <= 1'b0;
      stepPulse_q <= 1'b0;
      stepCount_q <= 8'd0;
      forceLow_q  <= 1'b0;
    end else begin
      keySync_q   <= {keySync_q[0], key_n};
      runSync_q   <= {runSync_q[0], run};
      keyLevel_q  <= keyLevel_d;
      dbCnt_q     <= dbCnt_d;
      div_q       <= div_d;
      stepClk_q   <= stepClk_d;
      stepPulse_q <= stepPulse_d;
      stepCount_q <= stepCount_d;
      forceLow_q  <= forceLow_d;
    end
  end

  assign step_clk   = stepClk_q;
  assign step_pulse = stepPulse_q;
  assign key_level  = keyLevel_q;
  assign step_count = stepCount_q;

endmodule

// File: tb/tb_step_clock_gen.sv
// Directed bench for step_clock_gen with DEBOUNCE_CYCLES=4, RUN_HALF=3:
// press latency, bounce rejection, free-run periods, mode switching, wrap, reset.
module tb_step_clock_gen;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       key_n    = 1'b1;
  logic       run      = 1'b0;
  logic [1:0] rate     = 2'd0;
  logic       step_clk, step_pulse, key_level;
  logic [7:0] step_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulseCount   = 0;
  int lastPulseCyc = 0;
  int lastPeriod   = 0;
  logic prevClk    = 1'b0;
  bit   started    = 1'b0;

  step_clock_gen #(.DEBOUNCE_CYCLES(4), .RUN_HALF(3)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .key_n     (key_n),
    .run       (run),
    .rate      (rate),
    .step_clk  (step_clk),
    .step_pulse(step_pulse),
    .key_level (key_level),
    .step_count(step_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic keyN, input logic runIn, input logic [1:0] rateIn);
    key_n = keyN;
    run   = runIn;
    rate  = rateIn;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  // A pulse must mark exactly the first high cycle of step_clk; also tally
  // pulses and the spacing between them for the period checks.
  always @(negedge CLOCK_50) begin
    if (started) begin
      checkOutput("pulse_def", {31'b0, step_pulse}, {31'b0, step_clk & ~prevClk});
      if (step_pulse) begin
        pulseCount++;
        lastPeriod   = cyc - lastPulseCyc;
        lastPulseCyc = cyc;
      end
    end
    prevClk = step_clk;
  end

  initial begin
    int p0;
    bit found;

    applyStimulus(1'b1, 1'b0, 2'd0);
    doReset();
    started = 1'b1;
    checkOutput("rst_clk", step_clk, 0);
    checkOutput("rst_pulse", step_pulse, 0);
    checkOutput("rst_level", key_level, 0);
    checkOutput("rst_count", step_count, 0);

    // Clean press: level rises 5 edges after first low sample, step one later
    pulseCount = 0;
    applyStimulus(1'b0, 1'b0, 2'd0);
    step(5);
    checkOutput("press_level_early", key_level, 0);
    step(1);
    checkOutput("press_level", key_level, 1);
    checkOutput("press_clk_early", step_clk, 0);
    step(1);
    checkOutput("press_clk", step_clk, 1);
    checkOutput("press_pulse", step_pulse, 1);
    checkOutput("press_count", step_count, 1);
    step(1);
    checkOutput("press_pulse_width", step_pulse, 0);
    checkOutput("press_clk_hold", step_clk, 1);
    step(12);
    applyStimulus(1'b1, 1'b0, 2'd0);
    step(12);
    checkOutput("release_level", key_level, 0);
    checkOutput("release_clk", step_clk, 0);
    checkOutput("release_pulses", pulseCount, 1);
    checkOutput("release_count", step_count, 1);

    // Bouncy press
    doReset();
    pulseCount = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(((i / 2) % 2) == 1, 1'b0, 2'd0);
      step(1);
    end
    checkOutput("bounce_level", key_level, 0);
    applyStimulus(1'b0, 1'b0, 2'd0);
    step(20);
    checkOutput("bounce_pulses", pulseCount, 1);
    checkOutput("bounce_count", step_count, 1);
    checkOutput("bounce_level_held", key_level, 1);
    applyStimulus(1'b1, 1'b0, 2'd0);
    step(12);

    // Free run at rate 0, then rate 1, then back to rate 0 with a large divider
    doReset();
    pulseCount = 0;
    applyStimulus(1'b1, 1'b1, 2'd0);
    step(4);
    checkOutput("run_first_early", step_clk, 0);
    step(1);
    checkOutput("run_first_toggle", step_clk, 1);
    step(55);
    checkOutput("run0_pulses", pulseCount, 10);
    checkOutput("run0_period", lastPeriod, 6);
    applyStimulus(1'b1, 1'b1, 2'd1);
    step(80);
    checkOutput("run1_period", lastPeriod, 24);
    checkOutput("run1_clk", step_clk, 1);
    applyStimulus(1'b1, 1'b1, 2'd0);
    step(1);
    checkOutput("rate_clamp_toggle", step_clk, 0);
    step(3);
    checkOutput("rate_clamp_next", step_clk, 1);

    // Held key across run->step: forced low until release, then one step
    applyStimulus(1'b0, 1'b1, 2'd0);
    step(8);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (step_clk && key_level) found = 1'b1;
      else step(1);
    end
    checkOutput("switch_wait", found, 1);
    applyStimulus(1'b0, 1'b0, 2'd0);
    step(3);
    checkOutput("switch_force_low", step_clk, 0);
    p0 = pulseCount;
    step(10);
    checkOutput("switch_stay_low", step_clk, 0);
    checkOutput("switch_no_pulse", pulseCount, p0);
    applyStimulus(1'b1, 1'b0, 2'd0);
    step(12);
    checkOutput("switch_release_clk", step_clk, 0);
    checkOutput("switch_release_level", key_level, 0);
    applyStimulus(1'b0, 1'b0, 2'd0);
    step(10);
    checkOutput("switch_repress_clk", step_clk, 1);
    checkOutput("switch_repress_pulses", pulseCount, p0 + 1);
    applyStimulus(1'b1, 1'b0, 2'd0);
    step(12);

    // 256 single steps wrap the counter
    doReset();
    pulseCount = 0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b0, 1'b0, 2'd0);
      step(8);
      applyStimulus(1'b1, 1'b0, 2'd0);
      step(8);
      if (i == 254) checkOutput("wrap_255", step_count, 255);
    end
    checkOutput("wrap_zero", step_count, 0);
    checkOutput("wrap_pulses", pulseCount, 256);

    // Reset for one cycle mid-run while step_clk is high
    applyStimulus(1'b1, 1'b1, 2'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      if (step_clk) found = 1'b1;
    end
    checkOutput("midrst_wait", found, 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checkOutput("midrst_clk", step_clk, 0);
    checkOutput("midrst_pulse", step_pulse, 0);
    checkOutput("midrst_level", key_level, 0);
    checkOutput("midrst_count", step_count, 0);
    step(4);
    checkOutput("midrst_quiet", step_clk, 0);
    step(1);
    checkOutput("midrst_toggle", step_clk, 1);
    checkOutput("midrst_count_after", step_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
